pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive data-memory wait cycles before fault.
REQ-002 SHALL have port clk  input  1  rising-edge clock, only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Rs1D, Rs2D  input  5 each  source regs of instruction in ID.
REQ-005 SHALL have port Rs1E, Rs2E, RdE  input  5 each  source/dest regs in EX.
REQ-006 SHALL have port MemReadE  input  1  EX instruction is a load.
REQ-007 SHALL have port PCSrcE  input  1  taken branch/jal/jalr resolved in EX.
REQ-008 SHALL have port RegWriteM, RdM  input  1/5  MEM-stage writeback info.
REQ-009 SHALL have port RegWriteW, RdW  input  1/5  WB-stage writeback info.
REQ-010 SHALL have port MemAccessM, MemReadyM  input  1 each  MEM-stage data memory request / ready.
REQ-011 SHALL have port StallF, StallD, StallE, StallM  output  1 each  hold stage register.
REQ-012 SHALL have port FlushD, FlushE  output  1 each  clear IF/ID, ID/EX register.
REQ-013 SHALL have port ForwardAE, ForwardBE  output  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-014 SHALL have port MemFault  output  1  sticky memory-timeout fault.
REQ-015 SHALL have ports StallCnt, FlushCnt  output  32 each  saturating perf counters.

Function
REQ-016 SHALL compute stall/flush/forward outputs combinationally in the same cycle from inputs and current state (zero latency).
REQ-017 SHALL set ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E, else 01 if RegWriteW && RdW!=0 && RdW==Rs1E, else 00; ForwardBE identical using Rs2E.
REQ-018 SHALL define MemHold = (MemAccessM && !MemReadyM) || state==FAULT.
REQ-019 SHALL, when MemHold, assert StallF, StallD, StallE, StallM and deassert FlushD, FlushE (priority 1).
REQ-020 SHALL, when !MemHold && PCSrcE, assert FlushD and FlushE, no stalls, load-use suppressed (priority 2).
REQ-021 SHALL, when neither above and MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D), assert StallF, StallD, FlushE (one bubble, priority 3).
REQ-022 SHALL otherwise drive all stall/flush outputs 0.
REQ-023 SHALL implement FSM states RUN, MEM_WAIT, FAULT.
REQ-024 RUN->MEM_WAIT when MemAccessM && !MemReadyM; WaitCnt loads 1.
REQ-025 MEM_WAIT: MemReadyM or !MemAccessM -> RUN, WaitCnt=0; else WaitCnt+1; when WaitCnt==MEM_TIMEOUT and still not ready -> FAULT.
REQ-026 FAULT SHALL be absorbing until reset; MemFault=1 in FAULT only.
REQ-027 StallCnt SHALL increment each cycle StallF=1; FlushCnt each cycle FlushE=1; both saturate at 32'hFFFFFFFF.
REQ-028 WaitCnt width SHALL be clog2(MEM_TIMEOUT+1) bits, never wraps.

Reset
REQ-029 On reset=1 at clk edge: state=RUN, WaitCnt=0, StallCnt=0, FlushCnt=0, MemFault=0.
REQ-030 Reset SHALL override any in-flight MEM_WAIT or FAULT in one cycle; combinational outputs follow inputs immediately after.

Structure
REQ-031 State enum, forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and MEM_TIMEOUT default SHALL live in shared package rv32i_pkg.
REQ-032 Forwarding logic (REQ-017) SHALL be sub-module forwarding_unit; hazard priority, FSM and counters in top.

Verification
REQ-033 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 same case -> ForwardAE=01 only if RdW nonzero.
REQ-034 MemReadE=1,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCnt+1, FlushCnt+1.
REQ-035 Load-use plus PCSrcE=1 same cycle -> FlushD=FlushE=1, StallF=0.
REQ-036 MemAccessM=1,MemReadyM=0 for 3 cycles then ready -> all four stalls high 3 cycles, state returns RUN, StallCnt=3.
REQ-037 MEM_TIMEOUT=4, ready never asserted -> MemFault=1 after WaitCnt reaches 4, stalls stay high; reset=1 -> MemFault=0, counters 0 next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package rv32i_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM result is younger than WB, so it wins when both target the same register.
    function automatic logic [1:0] fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic              reg_write_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              reg_write_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand bypass selection from the MEM and WB writeback ports.
module forwarding_unit
    import rv32i_pkg::*;
(
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
);

    always_comb begin
        ForwardAE = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: stall/flush priority, data-memory wait FSM with
// timeout fault, bypass selection and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic              MemAccessM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemFault,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    localparam int unsigned WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_pending;
    logic           mem_hold;
    logic           load_use;

    forwarding_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RegWriteM (RegWriteM),
        .RdM       (RdM),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    assign mem_pending = MemAccessM && !MemReadyM;
    assign mem_hold    = mem_pending || (state_q == FAULT);
    assign load_use    = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign MemFault    = (state_q == FAULT);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID and inject one bubble into EX.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_pending) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_pending) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            FAULT: ;
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            StallCnt   <= '0;
            FlushCnt   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (StallF && (StallCnt != CNT_MAX)) StallCnt <= StallCnt + 32'd1;
            if (FlushE && (FlushCnt != CNT_MAX)) FlushCnt <= FlushCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        MemReadE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemFault;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .MemReadE   (MemReadE),
        .PCSrcE     (PCSrcE),
        .RegWriteM  (RegWriteM),
        .RdM        (RdM),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .MemAccessM (MemAccessM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemFault   (MemFault),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_nr = 0;      // consecutive not-ready memory cycles
    bit     m_fault = 0;
    bit     m_valid = 0;
    longint m_sc = 0, m_fc = 0;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        logic       hold, lu;
        logic [3:0] e_st;
        logic [1:0] e_fl;
        hold = (MemAccessM && !MemReadyM) || m_fault;
        lu   = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (hold)        begin e_st = 4'b1111; e_fl = 2'b00; end
        else if (PCSrcE) begin e_st = 4'b0000; e_fl = 2'b11; end
        else if (lu)     begin e_st = 4'b1100; e_fl = 2'b01; end
        else             begin e_st = 4'b0000; e_fl = 2'b00; end
        if (m_valid) begin
            check("model_stalls", {28'd0, StallF, StallD, StallE, StallM}, {28'd0, e_st});
            check("model_flushes", {30'd0, FlushD, FlushE}, {30'd0, e_fl});
            check("model_fwdA", {30'd0, ForwardAE}, {30'd0, m_fwd(Rs1E)});
            check("model_fwdB", {30'd0, ForwardBE}, {30'd0, m_fwd(Rs2E)});
            check("model_fault", {31'd0, MemFault}, {31'd0, m_fault});
            check("model_stallcnt", StallCnt, m_sc[31:0]);
            check("model_flushcnt", FlushCnt, m_fc[31:0]);
        end
        if (reset) begin
            m_nr = 0; m_fault = 0; m_sc = 0; m_fc = 0; m_valid = 1;
        end else if (m_valid) begin
            if (e_st[3] && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (e_fl[0] && m_fc < 64'hFFFF_FFFF) m_fc++;
            if (!m_fault) begin
                if (MemAccessM && !MemReadyM) begin
                    m_nr++;
                    if (m_nr > TO) m_fault = 1;
                end else begin
                    m_nr = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        MemReadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemAccessM = 0; MemReadyM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_hz(input string name, input logic [3:0] st, input logic [1:0] fl);
        check({name, "_stalls"}, {28'd0, StallF, StallD, StallE, StallM}, {28'd0, st});
        check({name, "_flushes"}, {30'd0, FlushD, FlushE}, {30'd0, fl});
    endtask

    task automatic do_reset();
        next_cycle(); reset = 1; idle();
        next_cycle(); reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        next_cycle();
        next_cycle();
        reset = 0;
        settle();
        exp_hz("reset", 4'b0000, 2'b00);
        check("reset_stallcnt", StallCnt, 32'd0);
        check("reset_flushcnt", FlushCnt, 32'd0);
        check("reset_fault", {31'd0, MemFault}, 32'd0);

        // Forwarding
        next_cycle(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        settle(); check("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
        next_cycle(); RdM = 0;
        settle(); check("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        next_cycle(); RdW = 0;
        settle(); check("fwdA_x0", {30'd0, ForwardAE}, 32'd0);
        next_cycle(); idle(); RdW = 9; RegWriteW = 1; Rs2E = 9;
        settle(); check("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
        next_cycle(); RegWriteW = 0;
        settle(); check("fwdB_nowr", {30'd0, ForwardBE}, 32'd0);

        // Load-use bubble
        next_cycle(); idle(); MemReadE = 1; RdE = 7; Rs2D = 7;
        settle(); exp_hz("loaduse", 4'b1100, 2'b01);
        next_cycle(); idle(); MemReadE = 1; RdE = 0; Rs1D = 0;
        settle(); exp_hz("loaduse_x0", 4'b0000, 2'b00);
        check("loaduse_stallcnt", StallCnt, 32'd1);
        check("loaduse_flushcnt", FlushCnt, 32'd1);

        // Branch beats load-use
        next_cycle(); idle(); MemReadE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
        settle(); exp_hz("branch_lu", 4'b0000, 2'b11);
        next_cycle(); idle();
        settle();
        check("branch_stallcnt", StallCnt, 32'd1);
        check("branch_flushcnt", FlushCnt, 32'd2);

        // Three-cycle memory wait
        do_reset();
        idle(); MemAccessM = 1;
        settle(); exp_hz("wait1", 4'b1111, 2'b00);
        next_cycle(); PCSrcE = 1; MemReadE = 1; RdE = 4; Rs1D = 4;
        settle(); exp_hz("wait2_prio", 4'b1111, 2'b00);
        next_cycle(); idle(); MemAccessM = 1;
        settle(); exp_hz("wait3", 4'b1111, 2'b00);
        next_cycle(); MemReadyM = 1;
        settle(); exp_hz("ready", 4'b0000, 2'b00);
        next_cycle(); idle(); MemReadE = 1; RdE = 6; Rs1D = 6;
        settle(); exp_hz("after_wait_lu", 4'b1100, 2'b01);
        check("wait_stallcnt", StallCnt, 32'd3);
        check("wait_flushcnt", FlushCnt, 32'd0);
        check("wait_nofault", {31'd0, MemFault}, 32'd0);

        // Just below timeout: TO not-ready cycles then ready
        do_reset();
        idle(); MemAccessM = 1;
        repeat (TO - 1) next_cycle();
        next_cycle(); MemReadyM = 1;
        next_cycle(); idle();
        settle();
        check("edge_nofault", {31'd0, MemFault}, 32'd0);
        exp_hz("edge_run", 4'b0000, 2'b00);

        // Timeout: TO+1 not-ready cycles reach FAULT
        next_cycle(); MemAccessM = 1;
        repeat (TO) begin
            settle(); check("pre_fault", {31'd0, MemFault}, 32'd0);
            next_cycle();
        end
        settle(); check("last_wait", {31'd0, MemFault}, 32'd0);
        next_cycle(); idle();
        settle();
        check("fault_set", {31'd0, MemFault}, 32'd1);
        exp_hz("fault_hold", 4'b1111, 2'b00);
        next_cycle(); PCSrcE = 1;
        settle();
        check("fault_sticky", {31'd0, MemFault}, 32'd1);
        exp_hz("fault_hold2", 4'b1111, 2'b00);

        // Reset clears fault and counters
        do_reset();
        idle();
        settle();
        check("rst_fault", {31'd0, MemFault}, 32'd0);
        check("rst_stallcnt", StallCnt, 32'd0);
        check("rst_flushcnt", FlushCnt, 32'd0);
        exp_hz("rst_run", 4'b0000, 2'b00);

        // Mixed vectors, checked by the model
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            MemReadE   = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemAccessM = ($urandom_range(0, 2) == 0);
            MemReadyM  = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 40) == 0);
        end
        next_cycle(); reset = 0; idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
